mux_nw_scan: RTL and testbench

- Parametrised N-channel, WIDTH-bit multiplexer with registered output. Successor to the combinational 4:1 single-bit mux.
- Two select modes:
  - MANUAL: the select is latched from an input on a load strobe.
  - SCAN: the select auto-rotates through all channels, dwelling DWELL enabled cycles per channel.
- Sits between channel sources (sensors, test patterns) and a single downstream consumer that samples dout when dout_valid is high.

---
 rtl/mux_pkg.sv | 16 +
 rtl/mux_nw_scan_if.sv | 41 ++++
 rtl/mux_dwell_cnt.sv | 35 +++
 rtl/mux_nw_scan.sv | 94 +++++++++
 tb/tb_mux_nw_scan.sv | 181 ++++++++++++++++++
 5 files changed

// File: rtl/mux_pkg.sv
// Shared definitions for the scanning N-channel multiplexer.
//   MODE_MANUAL / MODE_SCAN : encodings of the mode input.
//   clog2_min1()            : counter width helper that never returns 0.
package mux_pkg;

    localparam logic MODE_MANUAL = 1'b0;
    localparam logic MODE_SCAN   = 1'b1;

    // $clog2(1) is 0, which is not a legal vector width; clamp to 1.
    function automatic int clog2_min1(input int value);
        int r;
        r = $clog2(value);
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/mux_nw_scan_if.sv
// Bus between channel sources / control and the scanning multiplexer.
//   din       : N packed channels, channel i = din[i*WIDTH +: WIDTH]
//   sel_in    : channel index latched on sel_load
//   sel_load  : one-cycle load strobe (honoured only while enable = 1)
//   mode      : MODE_MANUAL / MODE_SCAN
//   enable    : advance/sample enable
//   dout      : registered selected channel
//   dout_valid, sel_cur, wrap, sel_err : status back to the consumer
// Handshake: dout_valid is a pure valid with no ready. The consumer samples
// dout on every rising edge where dout_valid is 1; there is no backpressure,
// so a cycle with dout_valid = 0 simply carries no new sample.
interface mux_nw_scan_if #(
    parameter int WIDTH = 8,
    parameter int N     = 4
);
    import mux_pkg::*;

    localparam int SELW = $clog2(N);

    logic [N*WIDTH-1:0] din;
    logic [SELW-1:0]    sel_in;
    logic               sel_load;
    logic               mode;
    logic               enable;
    logic [WIDTH-1:0]   dout;
    logic               dout_valid;
    logic [SELW-1:0]    sel_cur;
    logic               wrap;
    logic               sel_err;

    modport master (
        output din, sel_in, sel_load, mode, enable,
        input  dout, dout_valid, sel_cur, wrap, sel_err
    );

    modport slave (
        input  din, sel_in, sel_load, mode, enable,
        output dout, dout_valid, sel_cur, wrap, sel_err
    );

endinterface

// File: rtl/mux_dwell_cnt.sv
// Dwell counter for SCAN mode: counts enabled cycles 0..DWELL-1 and wraps.
//   clk, rst_n : clock, asynchronous active-low reset
//   en         : count this cycle
//   clr        : force count to 0 (wins over en)
//   tc         : terminal count, high when count == DWELL-1 and en = 1
module mux_dwell_cnt
    import mux_pkg::*;
#(
    parameter int DWELL = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic clr,
    output logic tc
);

    localparam int CW = clog2_min1(DWELL);
    localparam logic [CW-1:0] TERM = CW'(DWELL - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= (cnt == TERM) ? '0 : cnt + CW'(1);
        end
    end

    assign tc = en && (cnt == TERM);

endmodule

// File: rtl/mux_nw_scan.sv
// N-channel, WIDTH-bit multiplexer with registered output and two select
// modes: MANUAL (select loaded from sel_in) and SCAN (select rotates through
// all channels, DWELL enabled cycles per channel).
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : mux_nw_scan_if slave (channels, control, dout and status)
module mux_nw_scan
    import mux_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int N     = 4,
    parameter int DWELL = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    mux_nw_scan_if.slave  bus
);

    localparam int SELW = $clog2(N);
    localparam logic [SELW:0]   N_EXT    = (SELW + 1)'(N);
    localparam logic [SELW-1:0] SEL_LAST = SELW'(N - 1);

    logic [SELW-1:0]  sel_q;
    logic             wrap_q;
    logic             err_q;
    logic [WIDTH-1:0] dout_q;
    logic             valid_q;

    logic             in_range;
    logic             load_ok;
    logic             load_bad;
    logic             scan_en;
    logic             dwell_clr;
    logic             dwell_tc;
    logic [WIDTH-1:0] chan;

    assign in_range  = ({1'b0, bus.sel_in} < N_EXT);
    assign load_ok   = bus.enable && bus.sel_load && in_range;
    assign load_bad  = bus.enable && bus.sel_load && !in_range;
    assign scan_en   = bus.enable && (bus.mode == MODE_SCAN);
    // MANUAL keeps the dwell count at 0, so a later switch to SCAN starts a
    // full DWELL period; a valid load also restarts the dwell period.
    assign dwell_clr = load_ok || (bus.enable && (bus.mode == MODE_MANUAL));

    mux_dwell_cnt #(
        .DWELL (DWELL)
    ) u_dwell (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (scan_en),
        .clr   (dwell_clr),
        .tc    (dwell_tc)
    );

    // Select register. A valid load beats the scan step, and suppresses wrap
    // even if the select was N-1 on a terminal edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel_q  <= '0;
            wrap_q <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            wrap_q <= 1'b0;
            err_q  <= load_bad;
            if (load_ok) begin
                sel_q <= bus.sel_in;
            end else if (dwell_tc) begin
                sel_q  <= (sel_q == SEL_LAST) ? '0 : sel_q + SELW'(1);
                wrap_q <= (sel_q == SEL_LAST);
            end
        end
    end

    // sel_q is always < N, so the part-select stays inside din.
    assign chan = bus.din[int'(sel_q) * WIDTH +: WIDTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dout_q  <= '0;
            valid_q <= 1'b0;
        end else if (bus.enable) begin
            dout_q  <= chan;
            valid_q <= 1'b1;
        end else begin
            valid_q <= 1'b0;
        end
    end

    assign bus.dout       = dout_q;
    assign bus.dout_valid = valid_q;
    assign bus.sel_cur    = sel_q;
    assign bus.wrap       = wrap_q;
    assign bus.sel_err    = err_q;

endmodule

// File: tb/tb_mux_nw_scan.sv
// Bench for mux_nw_scan: a 4-channel/DWELL=3 instance (A) and a
// 5-channel/DWELL=3 instance (B) for the out-of-range select case.
module tb_mux_nw_scan;
    import mux_pkg::*;

    localparam int EW = 14;  // {dout[8], valid, sel[3], wrap, err}

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mux_nw_scan_if #(.WIDTH(8), .N(4)) bus_a ();
    mux_nw_scan_if #(.WIDTH(8), .N(5)) bus_b ();

    mux_nw_scan #(.WIDTH(8), .N(4), .DWELL(3)) dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_a.slave)
    );

    mux_nw_scan #(.WIDTH(8), .N(5), .DWELL(3)) dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_b.slave)
    );

    int n_tests = 0;
    int n_fail  = 0;

    logic [EW-1:0] exp_a[$];
    logic [EW-1:0] exp_b[$];
    logic [7:0]    ch_a[4] = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};

    function automatic logic [EW-1:0] pack_exp(input logic [7:0] d, input logic v,
                                               input logic [2:0] s, input logic w,
                                               input logic e);
        return {d, v, s, w, e};
    endfunction

    task automatic check(input string name, input logic [EW-1:0] act,
                         input logic [EW-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s t=%0t: got dout=%h valid=%b sel=%0d wrap=%b err=%b, expected dout=%h valid=%b sel=%0d wrap=%b err=%b",
                     name, $time, act[13:6], act[5], act[4:2], act[1], act[0],
                     exp[13:6], exp[5], exp[4:2], exp[1], exp[0]);
        end
    endtask

    function automatic logic [EW-1:0] obs_a();
        return pack_exp(bus_a.dout, bus_a.dout_valid, 3'(bus_a.sel_cur), bus_a.wrap, bus_a.sel_err);
    endfunction

    function automatic logic [EW-1:0] obs_b();
        return pack_exp(bus_b.dout, bus_b.dout_valid, bus_b.sel_cur, bus_b.wrap, bus_b.sel_err);
    endfunction

    // Monitors: one expected entry per driven edge, compared 1 ns after it.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (exp_a.size() > 0) check("chan_a", obs_a(), exp_a.pop_front());
            if (exp_b.size() > 0) check("chan_b", obs_b(), exp_b.pop_front());
        end
    end

    // Drivers: apply inputs for the next edge and queue the state after it.
    task automatic drive_a(input logic en, input logic md, input logic ld,
                           input logic [1:0] si, input logic [7:0] d,
                           input logic v, input logic [2:0] s, input logic w);
        bus_a.enable   = en;
        bus_a.mode     = md;
        bus_a.sel_load = ld;
        bus_a.sel_in   = si;
        exp_a.push_back(pack_exp(d, v, s, w, 1'b0));
        @(posedge clk);
        #2;
    endtask

    task automatic drive_b(input logic ld, input logic [2:0] si, input logic [7:0] d,
                           input logic [2:0] s, input logic e);
        bus_b.enable   = 1'b1;
        bus_b.mode     = MODE_MANUAL;
        bus_b.sel_load = ld;
        bus_b.sel_in   = si;
        exp_b.push_back(pack_exp(d, 1'b1, s, 1'b0, e));
        @(posedge clk);
        #2;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        bus_a.din      = {8'hDD, 8'hCC, 8'hBB, 8'hAA};
        bus_a.enable   = 1'b1;
        bus_a.mode     = MODE_MANUAL;
        bus_a.sel_load = 1'b0;
        bus_a.sel_in   = '0;
        bus_b.din      = {8'hEE, 8'hDD, 8'hCC, 8'hBB, 8'hAA};
        bus_b.enable   = 1'b1;
        bus_b.mode     = MODE_MANUAL;
        bus_b.sel_load = 1'b0;
        bus_b.sel_in   = '0;

        // Reset held over 3 enabled edges.
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check("reset_a", obs_a(), pack_exp(8'h00, 1'b0, 3'd0, 1'b0, 1'b0));
        end
        check("reset_b", obs_b(), pack_exp(8'h00, 1'b0, 3'd0, 1'b0, 1'b0));
        #1;
        bus_b.enable = 1'b0;
        rst_n = 1'b1;

        // Manual load of channel 2, then enable low for two cycles.
        drive_a(1, MODE_MANUAL, 0, 2'd0, 8'hAA, 1, 3'd0, 0);
        drive_a(1, MODE_MANUAL, 1, 2'd2, 8'hAA, 1, 3'd2, 0);
        drive_a(1, MODE_MANUAL, 0, 2'd0, 8'hCC, 1, 3'd2, 0);
        drive_a(0, MODE_MANUAL, 0, 2'd0, 8'hCC, 0, 3'd2, 0);
        drive_a(0, MODE_MANUAL, 0, 2'd0, 8'hCC, 0, 3'd2, 0);
        drive_a(1, MODE_MANUAL, 0, 2'd0, 8'hCC, 1, 3'd2, 0);

        // Asynchronous reset between edges, then scan from reset.
        rst_n = 1'b0;
        #1;
        check("async_reset_manual", obs_a(), pack_exp(8'h00, 1'b0, 3'd0, 1'b0, 1'b0));
        #2;
        rst_n = 1'b1;
        for (int e = 1; e <= 23; e++) begin
            drive_a(1, MODE_SCAN, 0, 2'd0, ch_a[((e - 1) / 3) % 4], 1,
                    3'((e / 3) % 4), (e == 12));
        end

        // Load on the terminal edge with sel_cur = 3: no wrap, restart dwell.
        drive_a(1, MODE_SCAN, 1, 2'd1, 8'hDD, 1, 3'd1, 0);
        drive_a(1, MODE_SCAN, 0, 2'd0, 8'hBB, 1, 3'd1, 0);
        drive_a(1, MODE_SCAN, 0, 2'd0, 8'hBB, 1, 3'd1, 0);
        drive_a(1, MODE_SCAN, 0, 2'd0, 8'hBB, 1, 3'd2, 0);
        drive_a(1, MODE_SCAN, 0, 2'd0, 8'hCC, 1, 3'd2, 0);

        // Reset mid-scan while sel_cur = 2; scan restarts at channel 0.
        rst_n = 1'b0;
        #1;
        check("async_reset_scan", obs_a(), pack_exp(8'h00, 1'b0, 3'd0, 1'b0, 1'b0));
        #2;
        rst_n = 1'b1;
        for (int e = 1; e <= 4; e++) begin
            drive_a(1, MODE_SCAN, 0, 2'd0, ch_a[((e - 1) / 3) % 4], 1,
                    3'((e / 3) % 4), 0);
        end
        bus_a.enable = 1'b0;

        // N = 5: out-of-range load leaves sel_cur and dout alone.
        drive_b(1, 3'd4, 8'hAA, 3'd4, 0);
        drive_b(0, 3'd0, 8'hEE, 3'd4, 0);
        drive_b(1, 3'd6, 8'hEE, 3'd4, 1);
        drive_b(0, 3'd0, 8'hEE, 3'd4, 0);
        drive_b(1, 3'd3, 8'hEE, 3'd3, 0);
        drive_b(0, 3'd0, 8'hDD, 3'd3, 0);
        bus_b.enable = 1'b0;

        repeat (2) @(posedge clk);
        #2;
        n_tests++;
        if (exp_a.size() != 0 || exp_b.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d/%0d entries left, expected 0/0", exp_a.size(), exp_b.size());
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
